// File: rtl/edge_debounce.sv
// Debounces a synchronized level input, emits registered rise/fall pulses
// and keeps a saturating count of accepted rising changes with a sticky
// overflow flag.
module edge_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK_0,
  input  logic                 RESETN_0,
  input  logic                 D_SYNC,
  input  logic                 CLR_CNT,
  output logic                 LEVEL,
  output logic                 RISE,
  output logic                 FALL,
  output logic [CNT_WIDTH-1:0] EDGE_CNT,
  output logic                 OVF
);

  localparam int RUN_W = $clog2(DEB_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(DEB_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [RUN_W-1:0]       run_q, run_d, run_inc;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  // Count up but hold at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign run_inc = run_q + RUN_ONE;

  // Next-state logic: debounce FSM, pulse generation and the edge counter.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_LOW: begin
        if (D_SYNC) begin
          state_d = PEND_HIGH;
          run_d   = RUN_ONE;
        end else begin
          run_d   = '0;
        end
      end
      PEND_HIGH: begin
        if (D_SYNC) begin
          if (run_inc == RUN_TGT) begin
            state_d = ST_HIGH;
            run_d   = '0;
            rise_d  = 1'b1;
          end else begin
            run_d   = run_inc;
          end
        end else begin
          // Abandoned candidate: no pulse, no count.
          state_d = ST_LOW;
          run_d   = '0;
        end
      end
      ST_HIGH: begin
        if (!D_SYNC) begin
          state_d = PEND_LOW;
          run_d   = RUN_ONE;
        end else begin
          run_d   = '0;
        end
      end
      PEND_LOW: begin
        if (!D_SYNC) begin
          if (run_inc == RUN_TGT) begin
            state_d = ST_LOW;
            run_d   = '0;
            fall_d  = 1'b1;
          end else begin
            run_d   = run_inc;
          end
        end else begin
          state_d = ST_HIGH;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_LOW;
        run_d   = '0;
      end
    endcase

    level_d = (state_d == ST_HIGH) || (state_d == PEND_LOW);

    // Clear wins over a coincident rise; that rise is simply not counted.
    if (CLR_CNT) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (rise_d) begin
      cnt_d = sat_inc(cnt_q);
      ovf_d = ovf_q | (cnt_q == '1);
    end
  end

  // State and all outputs are registered; reset forces everything idle.
  always_ff @(posedge CLK_0 or negedge RESETN_0) begin
    if (!RESETN_0) begin
      state_q <= ST_LOW;
      run_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign LEVEL    = level_q;
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign EDGE_CNT = cnt_q;
  assign OVF      = ovf_q;

endmodule
